// File: rtl/wavegen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wavegen_pkg
//  Description : Shared types and elaboration-time helpers for the NCO
//                phase-to-amplitude path: waveform select encoding,
//                full-scale constant and quarter-sine table generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package wavegen_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_TRI    = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_SQUARE = 2'd3
  } wave_sel_e;

  // Fixed-point format used only while building the sine table.
  localparam int     c_frac_bits    = 28;
  localparam longint c_frac_one     = longint'(1) << c_frac_bits;
  localparam longint c_pi_q         = 64'sd843314857;  // pi * 2^28
  localparam int     c_taylor_terms = 8;

  // Largest positive magnitude of a symmetric signed sample: 2^(W-1)-1.
  function automatic int full_scale(input int data_w);
    return (1 << (data_w - 1)) - 1;
  endfunction

  // Quarter-sine table entry k: round(A * sin(2*pi*(k+0.5)/depth)).
  // Integer Taylor series keeps the table a pure elaboration constant;
  // the truncated remainder is far below half an LSB for any angle in
  // the first quadrant.
  function automatic int sine_rom_entry(input int k, input int depth, input int data_w);
    longint x;
    longint x2;
    longint term;
    longint acc;
    x    = (c_pi_q * longint'(2 * k + 1)) / longint'(depth);
    x2   = (x * x) >>> c_frac_bits;
    term = x;
    acc  = x;
    for (int n = 1; n <= c_taylor_terms; n++) begin
      term = -(((term * x2) >>> c_frac_bits) / longint'((2 * n) * (2 * n + 1)));
      acc  = acc + term;
    end
    acc = acc * longint'(full_scale(data_w)) + (c_frac_one >>> 1);
    return int'(acc >>> c_frac_bits);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sine_quarter_rom.sv
`default_nettype none
// ============================================================================
//  Module      : sine_quarter_rom
//  Description : Quarter-wave sine magnitude table (DEPTH/4 x DATA_W-1,
//                unsigned) with a registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module sine_quarter_rom
  import wavegen_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     en_i,
  input  logic [$clog2(DEPTH)-3:0] addr_i,
  output logic [DATA_W-2:0]        mag_o
);

  localparam int ROM_D = DEPTH / 4;

  logic [DATA_W-2:0] rom_table [ROM_D];
  logic [DATA_W-2:0] mag_q;

  for (genvar k = 0; k < ROM_D; k++) begin : g_rom_entry
    localparam int c_val = sine_rom_entry(k, DEPTH, DATA_W);
    assign rom_table[k] = c_val[DATA_W-2:0];
  end

  // Registered read; holds while no sample is moving through the stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mag_q <= '0;
    end else if (en_i) begin
      mag_q <= rom_table[addr_i];
    end
  end

  assign mag_o = mag_q;

endmodule
`default_nettype wire

// File: rtl/phase_to_amplitude_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : phase_to_amplitude_decoder
//  Description : Converts accumulator phase + expire into a gain-scaled,
//                saturated signed sample (sine/triangle/saw/square) through
//                a 3-stage pipeline, and counts completed periods.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_to_amplitude_decoder
  import wavegen_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic [$clog2(DEPTH)-1:0] i_phase,
  input  logic                     i_expire,
  input  logic [1:0]               i_wave_sel,
  input  logic [DATA_W-1:0]        i_amp,
  input  logic                     i_clr,
  output logic signed [DATA_W-1:0] o_sample,
  output logic                     o_valid,
  output logic                     o_cycle_start,
  output logic [CNT_W-1:0]         o_cycle_count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int MW  = PW - 2;          // quarter-wave index width
  localparam int TW  = DATA_W - 1;      // magnitude width
  localparam int PRW = 2 * DATA_W + 1;  // product width

  localparam int                      c_full_scale = full_scale(DATA_W);
  localparam logic signed [DATA_W-1:0] c_fs_pos    = DATA_W'(c_full_scale);
  localparam logic signed [DATA_W-1:0] c_fs_neg    = -c_fs_pos;
  localparam logic signed [PRW-1:0]    c_sat_pos   = PRW'(c_full_scale);
  localparam logic signed [PRW-1:0]    c_sat_neg   = -c_sat_pos;

  // --------------------------------------------------------------------
  // Stage 1: phase decode
  // --------------------------------------------------------------------
  logic [1:0]    quad_d;
  logic [MW-1:0] idx_d;
  logic [MW-1:0] mirror_d;

  assign quad_d   = i_phase[PW-1:PW-2];
  assign idx_d    = i_phase[MW-1:0];
  assign mirror_d = quad_d[0] ? ~idx_d : idx_d;

  logic              s1_valid_q;
  logic              s1_expire_q;
  logic [MW-1:0]     s1_mirror_q;
  logic              s1_neg_q;
  logic [PW-2:0]     s1_low_q;
  wave_sel_e         s1_sel_q;
  logic [DATA_W-1:0] s1_amp_q;

  // Capture decode, settings and expire together so one sample never mixes settings.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_expire_q <= 1'b0;
      s1_mirror_q <= '0;
      s1_neg_q    <= 1'b0;
      s1_low_q    <= '0;
      s1_sel_q    <= WAVE_SINE;
      s1_amp_q    <= '0;
    end else begin
      s1_valid_q  <= i_en;
      s1_expire_q <= i_en & i_expire;
      if (i_en) begin
        s1_mirror_q <= mirror_d;
        s1_neg_q    <= quad_d[1];
        s1_low_q    <= i_phase[PW-2:0];
        s1_sel_q    <= wave_sel_e'(i_wave_sel);
        s1_amp_q    <= i_amp;
      end
    end
  end

  // --------------------------------------------------------------------
  // Stage 2: ROM read and non-sine waveform build
  // --------------------------------------------------------------------
  logic [TW-1:0]            tri_mag_w;
  logic [PW-1:0]            saw_pw_w;
  logic signed [DATA_W-1:0] saw_w;
  logic signed [DATA_W-1:0] wave_d;
  logic [TW-1:0]            rom_mag_w;

  sine_quarter_rom #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_sine_rom (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .en_i    (s1_valid_q),
    .addr_i  (s1_mirror_q),
    .mag_o   (rom_mag_w)
  );

  // Mirrored index left-justified into the magnitude field.
  if (TW >= MW) begin : g_tri_pad
    assign tri_mag_w = TW'(s1_mirror_q) << (TW - MW);
  end else begin : g_tri_trunc
    assign tri_mag_w = s1_mirror_q[MW-1 -: TW];
  end

  // Offset-binary phase flipped to two's complement, then left-justified.
  assign saw_pw_w = {~s1_neg_q, s1_low_q};
  if (DATA_W >= PW) begin : g_saw_pad
    assign saw_w = DATA_W'(saw_pw_w) << (DATA_W - PW);
  end else begin : g_saw_trunc
    assign saw_w = saw_pw_w[PW-1 -: DATA_W];
  end

  // Select the non-sine waveform; sine arrives from the ROM register instead.
  always_comb begin
    wave_d = '0;
    case (s1_sel_q)
      WAVE_TRI:    wave_d = s1_neg_q ? -$signed({1'b0, tri_mag_w}) : $signed({1'b0, tri_mag_w});
      WAVE_SAW:    wave_d = saw_w;
      WAVE_SQUARE: wave_d = s1_neg_q ? c_fs_neg : c_fs_pos;
      default:     wave_d = '0;
    endcase
  end

  logic                     s2_valid_q;
  logic                     s2_expire_q;
  logic signed [DATA_W-1:0] s2_wave_q;
  logic                     s2_neg_q;
  wave_sel_e                s2_sel_q;
  logic [DATA_W-1:0]        s2_amp_q;

  // Carry waveform and the per-sample settings alongside the ROM read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_expire_q <= 1'b0;
      s2_wave_q   <= '0;
      s2_neg_q    <= 1'b0;
      s2_sel_q    <= WAVE_SINE;
      s2_amp_q    <= '0;
    end else begin
      s2_valid_q  <= s1_valid_q;
      s2_expire_q <= s1_expire_q;
      if (s1_valid_q) begin
        s2_wave_q <= wave_d;
        s2_neg_q  <= s1_neg_q;
        s2_sel_q  <= s1_sel_q;
        s2_amp_q  <= s1_amp_q;
      end
    end
  end

  // --------------------------------------------------------------------
  // Stage 3: gain, floor shift, symmetric saturation
  // --------------------------------------------------------------------
  logic signed [DATA_W-1:0] sine_w;
  logic signed [DATA_W-1:0] wave_w;
  logic signed [PRW-1:0]    wave_ext_w;
  logic signed [PRW-1:0]    amp_ext_w;
  logic signed [PRW-1:0]    prod_w;
  logic signed [PRW-1:0]    scaled_w;
  logic signed [DATA_W-1:0] sat_d;

  assign sine_w     = s2_neg_q ? -$signed({1'b0, rom_mag_w}) : $signed({1'b0, rom_mag_w});
  assign wave_w     = (s2_sel_q == WAVE_SINE) ? sine_w : s2_wave_q;
  assign wave_ext_w = PRW'(wave_w);
  assign amp_ext_w  = PRW'(s2_amp_q);
  assign prod_w     = wave_ext_w * amp_ext_w;
  assign scaled_w   = prod_w >>> (DATA_W - 1);

  // Clamp to +/-A so the most negative code is never produced.
  always_comb begin
    sat_d = scaled_w[DATA_W-1:0];
    if (scaled_w > c_sat_pos) begin
      sat_d = c_fs_pos;
    end else if (scaled_w < c_sat_neg) begin
      sat_d = c_fs_neg;
    end
  end

  logic signed [DATA_W-1:0] sample_q;
  logic                     valid_q;
  logic                     start_q;

  // Output register; the sample holds across bubbles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      valid_q <= s2_valid_q;
      start_q <= s2_valid_q & s2_expire_q;
      if (s2_valid_q) begin
        sample_q <= sat_d;
      end
    end
  end

  // --------------------------------------------------------------------
  // Completed-period counter
  // --------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority; otherwise count visible period starts, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (valid_q && start_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_sample      = sample_q;
  assign o_valid       = valid_q;
  assign o_cycle_start = start_q;
  assign o_cycle_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_to_amplitude_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_to_amplitude_decoder
//  Description : Directed self-checking bench for phase_to_amplitude_decoder
//                (DEPTH=128, DATA_W=8, A=127).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_to_amplitude_decoder;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [6:0]        phase;
  logic              expire;
  logic [1:0]        wave_sel;
  logic [7:0]        amp;
  logic              clr;
  logic signed [7:0] o_sample;
  logic              o_valid;
  logic              o_cycle_start;
  logic [15:0]       o_cycle_count;

  phase_to_amplitude_decoder #(
    .DEPTH  (128),
    .DATA_W (8),
    .CNT_W  (16)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_phase       (phase),
    .i_expire      (expire),
    .i_wave_sel    (wave_sel),
    .i_amp         (amp),
    .i_clr         (clr),
    .o_sample      (o_sample),
    .o_valid       (o_valid),
    .o_cycle_start (o_cycle_start),
    .o_cycle_count (o_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sample;
    int start;
  } exp_t;

  exp_t exp_q[$];
  int   log_q[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference waveform and scaling taken straight from the waveform definitions.
  function automatic int model(input int sel, input int p, input int g);
    int  w;
    int  s;
    real r;
    w = 0;
    case (sel)
      0: begin
        r = 127.0 * $sin(2.0 * 3.14159265358979 * (real'(p) + 0.5) / 128.0);
        w = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
      end
      1: begin
        if (p < 32)      w = 4 * p;
        else if (p < 64) w = 4 * (63 - p);
        else if (p < 96) w = -(4 * (p - 64));
        else             w = -(4 * (127 - p));
      end
      2: w = 2 * (p - 64);
      default: w = (p < 64) ? 127 : -127;
    endcase
    s = (w * g) >>> 7;
    if (s > 127)  s = 127;
    if (s < -127) s = -127;
    return s;
  endfunction

  task automatic drive(input bit e, input int p, input bit ex, input int sel, input int g);
    exp_t item;
    @(negedge clk);
    en       = e;
    phase    = 7'(p);
    expire   = ex;
    wave_sel = 2'(sel);
    amp      = 8'(g);
    if (e) begin
      item.sample = model(sel, p, g);
      item.start  = int'(ex);
      exp_q.push_back(item);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) drive(1'b0, 0, 1'b0, 0, 0);
  endtask

  // Scoreboard: every valid output is matched in order against the queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("sample", int'(o_sample), e.sample);
        check_val("cycle_start", int'(o_cycle_start), e.start);
        log_q.push_back(int'(o_sample));
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; phase = '0; expire = 1'b0;
    wave_sel = '0; amp = '0; clr = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_sample", int'(o_sample), 0);
    check_val("rst_valid", int'(o_valid), 0);
    check_val("rst_start", int'(o_cycle_start), 0);
    check_val("rst_count", int'(o_cycle_count), 0);
    rst_n = 1'b1;

    // Sine at unity gain, one full period
    log_q.delete();
    for (int p = 0; p < 128; p++) drive(1'b1, p, p == 0, 0, 128);
    drain(6);
    check_val("sin_len", log_q.size(), 128);
    check_val("sin_p0", log_q[0], 3);
    check_val("sin_p31", log_q[31], 127);
    check_val("sin_p32", log_q[32], 127);
    check_val("sin_p95", log_q[95], -127);
    check_val("sin_p96", log_q[96], -127);
    check_val("cnt_after_sine", int'(o_cycle_count), 1);

    // Square at max gain saturates
    log_q.delete();
    for (int p = 0; p < 128; p++) drive(1'b1, p, 1'b0, 3, 255);
    drain(6);
    check_val("sq_p0", log_q[0], 127);
    check_val("sq_p63", log_q[63], 127);
    check_val("sq_p64", log_q[64], -127);
    check_val("sq_p127", log_q[127], -127);
    check_val("hold_sample", int'(o_sample), -127);
    check_val("hold_valid", int'(o_valid), 0);

    // Sawtooth at unity gain
    log_q.delete();
    for (int p = 0; p < 128; p++) drive(1'b1, p, 1'b0, 2, 128);
    drain(6);
    check_val("saw_p0", log_q[0], -127);
    check_val("saw_p64", log_q[64], 0);
    check_val("saw_p127", log_q[127], 126);

    // Triangle at half gain
    log_q.delete();
    drive(1'b1, 0, 1'b0, 1, 64);
    drive(1'b1, 32, 1'b0, 1, 64);
    drive(1'b1, 96, 1'b0, 1, 64);
    drain(6);
    check_val("tri_p0", log_q[0], 0);
    check_val("tri_p32", log_q[1], 62);
    check_val("tri_p96", log_q[2], -62);

    // Selection and gain changes between consecutive samples
    log_q.delete();
    drive(1'b1, 40, 1'b0, 1, 128);
    drive(1'b1, 40, 1'b0, 3, 128);
    drive(1'b1, 40, 1'b0, 3, 128);
    drive(1'b1, 100, 1'b0, 2, 128);
    drive(1'b1, 100, 1'b0, 2, 64);
    drain(6);
    check_val("sw_tri", log_q[0], 92);
    check_val("sw_sq", log_q[1], 127);
    check_val("sw_sq2", log_q[2], 127);
    check_val("sw_saw_g128", log_q[3], 72);
    check_val("sw_saw_g64", log_q[4], 36);

    // Counter: clear, three periods, dropped expire, clear wins over increment
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check_val("cnt_clr", int'(o_cycle_count), 0);
    for (int i = 0; i < 3; i++) drive(1'b1, 0, 1'b1, 0, 128);
    drain(6);
    check_val("cnt_three", int'(o_cycle_count), 3);
    drive(1'b0, 0, 1'b1, 0, 128);
    drain(6);
    check_val("cnt_no_en", int'(o_cycle_count), 3);
    drive(1'b1, 0, 1'b1, 0, 128);
    drive(1'b0, 0, 1'b0, 0, 0);
    drive(1'b0, 0, 1'b0, 0, 0);
    @(negedge clk);
    check_val("clr_coincide_start", int'(o_cycle_start), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_val("cnt_clr_wins", int'(o_cycle_count), 0);
    drain(4);

    // Counter saturation
    for (int i = 0; i < 65540; i++) drive(1'b1, 0, 1'b1, 0, 128);
    drain(6);
    check_val("cnt_sat", int'(o_cycle_count), 65535);
    log_q.delete();

    // Reset in the middle of a stream
    for (int p = 10; p < 20; p++) drive(1'b1, p, 1'b0, 0, 128);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_sample", int'(o_sample), 0);
    check_val("mid_rst_valid", int'(o_valid), 0);
    check_val("mid_rst_start", int'(o_cycle_start), 0);
    check_val("mid_rst_count", int'(o_cycle_count), 0);
    exp_q.delete();
    @(negedge clk);
    en = 1'b0; expire = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drain(3);
    check_val("post_rst_idle", int'(o_valid), 0);

    // First-sample latency after reset
    drive(1'b1, 0, 1'b1, 0, 128);
    drive(1'b0, 0, 1'b0, 0, 0);
    check_val("lat_edge1", int'(o_valid), 0);
    drive(1'b0, 0, 1'b0, 0, 0);
    check_val("lat_edge2", int'(o_valid), 0);
    drive(1'b0, 0, 1'b0, 0, 0);
    check_val("lat_edge3", int'(o_valid), 1);
    drain(4);
    check_val("leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
